// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer in front of a word-wide data RAM.
// Define MEM_MISALIGN_CHECK_EN to trap misaligned halfword/word accesses instead of aligning them.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 8
`endif

module mem_access_ctrl (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  L_type,
    input  logic                  S_type,
    input  logic [2:0]            funct3,
    input  logic [`DATAWIDTH-1:0] addr,
    input  logic [`DATAWIDTH-1:0] wdata,
    input  logic [`DATAWIDTH-1:0] ram_rdata,
    output logic                  data_RAM_R_en,
    output logic                  data_RAM_W_en,
    output logic [`ADDRWIDTH-1:0] ram_adder,
    output logic [`DATAWIDTH-1:0] ram_wdata,
    output logic [`DATAWIDTH-1:0] load_data,
    output logic                  pipe_ready_go,
    output logic                  misalign_err
);

    typedef enum logic [1:0] {IDLE, LD_WAIT, ST_MERGE} state_t;

    state_t                r_state;
    logic                  w_isStore;
    logic                  w_isLoad;
    logic                  w_isWord;
    logic                  w_isHalf;
    logic                  w_misalign;
    logic                  w_unused;
    logic [4:0]            w_byteShift;
    logic [4:0]            w_halfShift;
    logic [`DATAWIDTH-1:0] w_byteMask;
    logic [`DATAWIDTH-1:0] w_halfMask;
    logic [`DATAWIDTH-1:0] w_rdShifted;
    logic [`DATAWIDTH-1:0] w_extended;
    logic [`DATAWIDTH-1:0] w_merged;

    // A simultaneous load and store request is served as a store.
    assign w_isStore   = S_type;
    assign w_isLoad    = L_type & ~S_type;
    assign w_isWord    = funct3[1];
    assign w_isHalf    = (funct3[1:0] == 2'b01);

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misalign  = (w_isStore | w_isLoad) &
                         ((w_isHalf & addr[0]) | (w_isWord & (addr[1:0] != 2'b00)));
`else
    assign w_misalign  = 1'b0;
`endif

    assign ram_adder   = addr[`ADDRWIDTH+1:2];
    assign w_unused    = &{1'b0, addr[`DATAWIDTH-1:`ADDRWIDTH+2]};

    // Halfword lanes only look at addr[1], so an odd halfword address falls back to its aligned lane.
    assign w_byteShift = {addr[1:0], 3'b000};
    assign w_halfShift = {addr[1], 4'b0000};
    assign w_rdShifted = ram_rdata >> (w_isHalf ? w_halfShift : w_byteShift);
    assign w_byteMask  = 32'h0000_00FF << w_byteShift;
    assign w_halfMask  = 32'h0000_FFFF << w_halfShift;

    always_comb begin
        w_extended = ram_rdata;
        if (w_isHalf) begin
            w_extended = {{16{~funct3[2] & w_rdShifted[15]}}, w_rdShifted[15:0]};
        end else if (!w_isWord) begin
            w_extended = {{24{~funct3[2] & w_rdShifted[7]}}, w_rdShifted[7:0]};
        end
    end

    assign w_merged = w_isHalf ?
                      ((ram_rdata & ~w_halfMask) | ({16'h0000, wdata[15:0]} << w_halfShift)) :
                      ((ram_rdata & ~w_byteMask) | ({24'h000000, wdata[7:0]} << w_byteShift));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_misalign) begin
                        r_state <= IDLE;
                    end else if (w_isStore && !w_isWord) begin
                        r_state <= ST_MERGE;
                    end else if (w_isLoad) begin
                        r_state <= LD_WAIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // While rst_n is low every output shows the quiet IDLE values, whatever the requests say.
    always_comb begin
        data_RAM_R_en = 1'b0;
        data_RAM_W_en = 1'b0;
        pipe_ready_go = 1'b1;
        ram_wdata     = wdata;
        load_data     = '0;
        misalign_err  = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (w_misalign) begin
                        misalign_err = 1'b1;
                    end else if (w_isStore) begin
                        if (w_isWord) begin
                            data_RAM_W_en = 1'b1;
                        end else begin
                            data_RAM_R_en = 1'b1;
                            pipe_ready_go = 1'b0;
                        end
                    end else if (w_isLoad) begin
                        data_RAM_R_en = 1'b1;
                        pipe_ready_go = 1'b0;
                    end
                end
                LD_WAIT: begin
                    load_data = w_extended;
                end
                ST_MERGE: begin
                    data_RAM_W_en = 1'b1;
                    ram_wdata     = w_merged;
                end
                default: begin
                    pipe_ready_go = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench for mem_access_ctrl with a byte-level transaction model and a RAM.
// Build with MEM_MISALIGN_CHECK_EN defined to exercise the misalignment trap.
`timescale 1ns/1ps
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 8
`endif

module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        L_type = 1'b0;
    logic        S_type = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] ram_rdata = 32'h0;
    logic        data_RAM_R_en;
    logic        data_RAM_W_en;
    logic [7:0]  ram_adder;
    logic [31:0] ram_wdata;
    logic [31:0] load_data;
    logic        pipe_ready_go;
    logic        misalign_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [256];
    logic [31:0] refMem [256];
    bit          checkEn = 1'b0;
    int          curPhase = 0;

    bit          obsRen [2];
    bit          obsWen [2];
    bit          obsReady [2];
    bit          obsMis [2];
    logic [7:0]  obsAdder [2];
    logic [31:0] obsLoad [2];
    logic [31:0] obsWdata [2];

    int          mN;
    bit          mLd;
    bit          mSt;
    bit          mMis;
    bit          eRen;
    bit          eWen;
    bit          eReady;
    logic [31:0] mOld;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .L_type        (L_type),
        .S_type        (S_type),
        .funct3        (funct3),
        .addr          (addr),
        .wdata         (wdata),
        .ram_rdata     (ram_rdata),
        .data_RAM_R_en (data_RAM_R_en),
        .data_RAM_W_en (data_RAM_W_en),
        .ram_adder     (ram_adder),
        .ram_wdata     (ram_wdata),
        .load_data     (load_data),
        .pipe_ready_go (pipe_ready_go),
        .misalign_err  (misalign_err)
    );

    // Synchronous data RAM: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (data_RAM_W_en) mem[ram_adder] <= ram_wdata;
        if (data_RAM_R_en) ram_rdata <= mem[ram_adder];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit isMis(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b01) return a[0];
        if (f3[1]) return (a[1:0] != 2'b00);
        return 1'b0;
    endfunction

    // Number of cycles the access occupies the MEM stage.
    function automatic int nCycles(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (!ld && !st) return 1;
        if (MIS_EN && isMis(f3, a)) return 1;
        if (st && f3[1]) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [7:0]  b [4];
        logic [15:0] h;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        h = {b[{a[1], 1'b1}], b[{a[1], 1'b0}]};
        case (f3)
            3'b000:  return {{24{b[a[1:0]][7]}}, b[a[1:0]]};
            3'b100:  return {24'h0, b[a[1:0]]};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] mergeWord(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (f3[1:0] == 2'b00) begin
            b[a[1:0]] = wd[7:0];
        end else begin
            b[{a[1], 1'b0}] = wd[7:0];
            b[{a[1], 1'b1}] = wd[15:8];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            mLd    = L_type & ~S_type;
            mSt    = S_type;
            mN     = nCycles(mLd, mSt, funct3, addr);
            mOld   = refMem[addr[9:2]];
            mMis   = MIS_EN && (mLd || mSt) && isMis(funct3, addr);
            eRen   = (mN == 2) && (curPhase == 0);
            eWen   = mSt && !mMis && ((mN == 1) || (curPhase == 1));
            eReady = (curPhase == mN - 1);
            obsRen[curPhase[0]]   = data_RAM_R_en;
            obsWen[curPhase[0]]   = data_RAM_W_en;
            obsReady[curPhase[0]] = pipe_ready_go;
            obsMis[curPhase[0]]   = misalign_err;
            obsAdder[curPhase[0]] = ram_adder;
            obsLoad[curPhase[0]]  = load_data;
            obsWdata[curPhase[0]] = ram_wdata;
            checkOutput("R_en", {31'h0, data_RAM_R_en}, {31'h0, eRen});
            checkOutput("W_en", {31'h0, data_RAM_W_en}, {31'h0, eWen});
            checkOutput("ready", {31'h0, pipe_ready_go}, {31'h0, eReady});
            checkOutput("misalign", {31'h0, misalign_err}, {31'h0, mMis});
            checkOutput("ram_adder", {24'h0, ram_adder}, {24'h0, addr[9:2]});
            if (eWen) begin
                checkOutput("ram_wdata", ram_wdata, funct3[1] ? wdata : mergeWord(mOld, funct3, addr, wdata));
            end
            if (mLd && (mN == 2) && (curPhase == 1)) begin
                checkOutput("load_data", load_data, extract(mOld, funct3, addr));
            end
            if (mMis) begin
                checkOutput("load_data_mis", load_data, 32'h0);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that completes the access.
    task automatic applyStimulus(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
        int n;
        L_type = ld;
        S_type = st;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        n      = nCycles(ld & ~st, st, f3, a);
        checkEn = 1'b1;
        for (int p = 0; p < n; p++) begin
            curPhase = p;
            @(posedge clk);
            #1;
        end
        if (st && !(MIS_EN && isMis(f3, a))) begin
            refMem[a[9:2]] = f3[1] ? wd : mergeWord(refMem[a[9:2]], f3, a, wd);
        end
        L_type   = 1'b0;
        S_type   = 1'b0;
        curPhase = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = (32'h0101_0101 * i) ^ 32'h5A5A_0000;
            refMem[i] = (32'h0101_0101 * i) ^ 32'h5A5A_0000;
        end
        mem[0] = 32'hCAFE_F00D;  refMem[0] = 32'hCAFE_F00D;
        mem[3] = 32'h7654_3210;  refMem[3] = 32'h7654_3210;
        mem[4] = 32'hDEAD_BEEF;  refMem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'h1122_3344;  refMem[8] = 32'h1122_3344;

        L_type = 1'b1;
        funct3 = 3'b010;
        addr   = 32'h10;
        #12;
        checkOutput("rst_R_en", {31'h0, data_RAM_R_en}, 32'h0);
        checkOutput("rst_W_en", {31'h0, data_RAM_W_en}, 32'h0);
        checkOutput("rst_ready", {31'h0, pipe_ready_go}, 32'h1);
        checkOutput("rst_load_data", load_data, 32'h0);
        checkOutput("rst_misalign", {31'h0, misalign_err}, 32'h0);
        @(negedge clk);
        L_type = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checkOutput("lw_ren0", {31'h0, obsRen[0]}, 32'h1);
        checkOutput("lw_adder0", {24'h0, obsAdder[0]}, 32'h04);
        checkOutput("lw_ready0", {31'h0, obsReady[0]}, 32'h0);
        checkOutput("lw_load1", obsLoad[1], 32'hDEAD_BEEF);
        checkOutput("lw_ready1", {31'h0, obsReady[1]}, 32'h1);

        applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'h80FF_0000);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
        checkOutput("lb_load", obsLoad[1], 32'hFFFF_FF80);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        checkOutput("lbu_load", obsLoad[1], 32'h0000_0080);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
        checkOutput("lh_load", obsLoad[1], 32'hFFFF_80FF);
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
        checkOutput("lhu_load", obsLoad[1], 32'h0000_80FF);

        applyStimulus(1'b0, 1'b1, 3'b000, 32'h21, 32'h0000_00AA);
        checkOutput("sb_ren0", {31'h0, obsRen[0]}, 32'h1);
        checkOutput("sb_ready0", {31'h0, obsReady[0]}, 32'h0);
        checkOutput("sb_wen1", {31'h0, obsWen[1]}, 32'h1);
        checkOutput("sb_wdata1", obsWdata[1], 32'h1122_AA44);

        applyStimulus(1'b0, 1'b1, 3'b010, 32'h08, 32'h1234_5678);
        checkOutput("sw_wen", {31'h0, obsWen[0]}, 32'h1);
        checkOutput("sw_ren", {31'h0, obsRen[0]}, 32'h0);
        checkOutput("sw_wdata", obsWdata[0], 32'h1234_5678);
        checkOutput("sw_ready", {31'h0, obsReady[0]}, 32'h1);

        applyStimulus(1'b0, 1'b1, 3'b001, 32'h0E, 32'h0000_BEEF);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0C, 32'h0);
        checkOutput("sh_readback", obsLoad[1], 32'hBEEF_3210);

        applyStimulus(1'b1, 1'b1, 3'b000, 32'h30, 32'h0000_0077);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h30, 32'h0);
        checkOutput("ls_both_store", obsLoad[1], 32'h0000_0077);

        applyStimulus(1'b0, 1'b0, 3'b000, 32'h44, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h13, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h05, 32'h0000_1234);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h302, 32'h0);

        applyStimulus(1'b1, 1'b0, 3'b010, 32'h02, 32'h0);
`ifdef MEM_MISALIGN_CHECK_EN
        checkOutput("mis_err", {31'h0, obsMis[0]}, 32'h1);
        checkOutput("mis_ready", {31'h0, obsReady[0]}, 32'h1);
        checkOutput("mis_ren", {31'h0, obsRen[0]}, 32'h0);
        checkOutput("mis_wen", {31'h0, obsWen[0]}, 32'h0);
`else
        checkOutput("mis_ren0", {31'h0, obsRen[0]}, 32'h1);
        checkOutput("mis_adder0", {24'h0, obsAdder[0]}, 32'h00);
        checkOutput("mis_load1", obsLoad[1], 32'hCAFE_F00D);
`endif

        checkEn = 1'b0;
        S_type  = 1'b1;
        funct3  = 3'b001;
        addr    = 32'h06;
        wdata   = 32'h0000_5555;
        @(posedge clk);
        #1;
        checkOutput("merge_wen_pre", {31'h0, data_RAM_W_en}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_wen", {31'h0, data_RAM_W_en}, 32'h0);
        checkOutput("abort_ren", {31'h0, data_RAM_R_en}, 32'h0);
        checkOutput("abort_ready", {31'h0, pipe_ready_go}, 32'h1);
        checkOutput("abort_load", load_data, 32'h0);
        @(posedge clk);
        #1;
        S_type = 1'b0;
        rst_n  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_wen", {31'h0, data_RAM_W_en}, 32'h0);
            checkOutput("post_ren", {31'h0, data_RAM_R_en}, 32'h0);
            checkOutput("post_ready", {31'h0, pipe_ready_go}, 32'h1);
        end
        checkOutput("abort_mem", mem[1], refMem[1]);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checkOutput("post_lw_load", obsLoad[1], 32'h80FF_0000);
        checkEn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
